mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 SHALL have ports clk input 1 (sole clock, rising edge) and rst input 1 (reset, asynchronous, active-high); one clock, all state in clk domain.
REQ-004 SHALL have, per requester p in {0=core, 1=loader}: req_p input 1 (access request); we_p input 1 (1=write); addr_p input ADDR_W (word address); wdata_p input DATA_W (write data); lock_p input 1 (keep grant after this access); ack_p output 1 (request accepted this cycle); rvalid_p output 1 (read data valid); rdata_p output DATA_W (read data).
REQ-005 SHALL have RAM-side ports ram_addr output ADDR_W, ram_data output DATA_W, ram_wren output 1, ram_q input DATA_W (single-port synchronous RAM, q valid the cycle after address is sampled).
REQ-006 SHALL have owner output 1 (requester holding or last granted the RAM) and locked output 1 (lock state active).

Function
REQ-007 SHALL accept at most one access per cycle; ack_0 and ack_1 never both high.
REQ-008 SHALL drive ram_addr/ram_data/ram_wren combinationally from the acked requester in the same cycle; with no ack: ram_wren=0, ram_addr=last driven address, ram_data=0.
REQ-009 SHALL assert ack_p combinationally only when req_p=1 and requester p wins arbitration; a requester holds req/we/addr/wdata stable until acked.
REQ-010 SHALL assert rvalid_p exactly one cycle after an acked read (we_p=0), with rdata_p=ram_q during that cycle; rvalid_p stays 0 after writes.
REQ-011 SHALL hold rdata_p at its last valid value when rvalid_p=0.
REQ-012 SHALL implement state machine IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-013 IDLE: both requesting -> winner per REQ-018; single requester -> that requester acked.
REQ-014 IDLE -> LOCKp when ack_p=1 and lock_p=1 in the same cycle.
REQ-015 LOCKp: only requester p acked; other requester waits, ack stays 0.
REQ-016 LOCKp -> IDLE on the first cycle in which lock_p=0 (lock released, with or without a req_p); if req_p=1 that cycle it is still acked as owner.
REQ-017 owner SHALL update to the acked requester on every ack; locked=1 exactly in LOCK0/LOCK1.
REQ-018 Default (macro absent): fixed priority, loader (1) beats core (0) in IDLE.
REQ-019 Back-to-back accesses by the same requester on consecutive cycles SHALL each be acked with no bubble; rvalid pipelines accordingly.
REQ-020 Read and write to same address on consecutive cycles: read returns RAM contents (write-before-read ordering is the RAM's; arbiter adds none).

Reset
REQ-021 On rst=1, immediately: state IDLE, owner=0, locked=0, ack_0/1=0, rvalid_0/1=0, rdata_0/1=0, ram_wren=0, ram_addr=0, ram_data=0.
REQ-022 A read acked in the cycle rst asserts SHALL produce no rvalid; after rst deassert, arbitration resumes from IDLE on the next rising edge.

Configuration
REQ-023 Macro MEM_ARB_RR_EN defined: IDLE arbitration is round-robin, the requester that is not owner wins a tie; owner ties reset to 0 so loader wins first tie.
REQ-024 Macro MEM_ARB_RR_EN absent: fixed priority per REQ-018; all other behaviour identical.

Verification
REQ-025 Core-only read: req_0=1, we_0=0, addr_0=0x10, RAM[0x10]=0xDEADBEEF -> ack_0=1 cycle N, rvalid_0=1 and rdata_0=0xDEADBEEF cycle N+1.
REQ-026 Simultaneous reads, 3 cycles, both requesting, macro absent -> ack_1 all 3 cycles, ack_0=0; with MEM_ARB_RR_EN -> acks alternate 1,0,1.
REQ-027 Loader lock: loader writes 0x0..0x3 with lock_1=1 while req_0=1 -> ack_0=0 for 4 cycles, locked=1; lock_1=0 with final write -> IDLE, ack_0=1 next cycle.
REQ-028 Write then read: req_1 write 0x5=0x1234, then req_1 read 0x5 -> rvalid_1 with rdata_1=0x1234, ram_wren=1 only on write cycle.
REQ-029 Reset mid-read: ack_0 read at cycle N, rst=1 at N -> rvalid_0=0 at N+1, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (0=core, 1=loader) for a single-port synchronous RAM.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default is fixed priority, loader first.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              lock_0,
  output logic              ack_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic              lock_1,
  output logic              ack_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              owner,
  output logic              locked
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ack0, ack1;

  // Arbitration and lock state transitions
  always_comb begin
    state_d = state_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_0 && req_1) begin
`ifdef MEM_ARB_RR_EN
          if (owner_q) ack0 = 1'b1;
          else         ack1 = 1'b1;
`else
          ack1 = 1'b1;
`endif
        end else if (req_1) begin
          ack1 = 1'b1;
        end else if (req_0) begin
          ack0 = 1'b1;
        end
        if (ack1 && lock_1)      state_d = LOCK1;
        else if (ack0 && lock_0) state_d = LOCK0;
      end
      LOCK0: begin
        ack0 = req_0;
        if (!lock_0) state_d = IDLE;
      end
      LOCK1: begin
        ack1 = req_1;
        if (!lock_1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset takes effect on the outputs immediately, not at the next edge
    if (rst) begin
      ack0 = 1'b0;
      ack1 = 1'b0;
    end
  end

  // RAM-side mux and bookkeeping for the next cycle
  always_comb begin
    ram_addr    = last_addr_q;
    ram_data    = '0;
    ram_wren    = 1'b0;
    owner_d     = owner_q;
    rvalid0_d   = ack0 & ~we_0;
    rvalid1_d   = ack1 & ~we_1;
    rdata0_d    = rvalid0_q ? ram_q : rdata0_q;
    rdata1_d    = rvalid1_q ? ram_q : rdata1_q;
    if (ack1) begin
      ram_addr = addr_1;
      ram_data = wdata_1;
      ram_wren = we_1;
      owner_d  = 1'b1;
    end else if (ack0) begin
      ram_addr = addr_0;
      ram_data = wdata_0;
      ram_wren = we_0;
      owner_d  = 1'b0;
    end
    last_addr_d = ram_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_addr_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_addr_q <= last_addr_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign ack_0    = ack0;
  assign ack_1    = ack1;
  assign rvalid_0 = rvalid0_q;
  assign rvalid_1 = rvalid1_q;
  // Read data is passed straight from the RAM while valid, otherwise held
  assign rdata_0  = rvalid0_q ? ram_q : rdata0_q;
  assign rdata_1  = rvalid1_q ? ram_q : rdata1_q;
  assign owner    = owner_q;
  assign locked   = (state_q == LOCK0) || (state_q == LOCK1);

endmodule
